// File: rtl/acc_proc_core_pkg.sv
// Shared definitions for the accumulator processor core.
// Contents: opcode encodings, FSM state encodings and small decode helpers
// used by both the top level and the ALU.
package acc_proc_core_pkg;

  // Opcodes occupy the low 5 bits of the opcode field; wider fields must
  // have their upper bits clear to be considered defined.
  localparam int OPC_BASE_W = 5;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_LDI   = 5'd1,
    OP_LDM   = 5'd2,
    OP_STM   = 5'd3,
    OP_MOVR  = 5'd4,
    OP_MOVA  = 5'd5,
    OP_LDAR  = 5'd6,
    OP_ADD   = 5'd7,
    OP_SUB   = 5'd8,
    OP_MUL   = 5'd9,
    OP_INC   = 5'd10,
    OP_CLR   = 5'd11,
    OP_INCAR = 5'd12,
    OP_JMP   = 5'd13,
    OP_JMPZ  = 5'd14,
    OP_JMPNZ = 5'd15,
    OP_HALT  = 5'd31
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_MEM,
    ST_HALTED
  } state_e;

  function automatic logic op_defined(input logic [OPC_BASE_W-1:0] op);
    return (op <= 5'd15) || (op == 5'd31);
  endfunction

  // Ops whose operand names a general register and must be range checked.
  function automatic logic op_uses_reg(input opcode_e op);
    return (op == OP_MOVR) || (op == OP_MOVA) || (op == OP_ADD) ||
           (op == OP_SUB)  || (op == OP_MUL);
  endfunction

  // Ops that produce a new accumulator value from the ALU (and update Z).
  function automatic logic op_writes_ac(input opcode_e op);
    return (op == OP_LDI) || (op == OP_MOVA) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_MUL)  || (op == OP_INC) ||
           (op == OP_CLR);
  endfunction

endpackage

// File: rtl/acc_proc_core_alu.sv
// Combinational ALU for the accumulator core.
// Ports:
//   op     decoded opcode (illegal ops arrive here already mapped to NOP)
//   ac     current accumulator
//   rk     selected general register
//   imm    instruction operand
//   result new accumulator value (equals ac for ops that do not write AC)
//   zero   result == 0
module acc_proc_core_alu
  import acc_proc_core_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] rk,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // All arithmetic is naturally truncated to DATA_W, giving the wrapping
  // behaviour; MUL keeps only the low half of the product.
  always_comb begin
    result = ac;
    case (op)
      OP_LDI:  result = imm;
      OP_MOVA: result = rk;
      OP_ADD:  result = ac + rk;
      OP_SUB:  result = ac - rk;
      OP_MUL:  result = ac * rk;
      OP_INC:  result = ac + DATA_W'(1);
      OP_CLR:  result = '0;
      default: result = ac;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/acc_proc_core.sv
// Parametrised accumulator processor core.
// Fetches {opcode, operand} words from a synchronous instruction memory and
// executes them on AC, AR, PC and NUM_GPR general registers. Data memory is
// accessed through a req/ack handshake of arbitrary latency.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               run from PC=0 (only in IDLE or HALTED)
//   im_addr / im_data   instruction memory (data valid one cycle after addr)
//   dm_req/we/addr/wdata/rdata/ack   data memory handshake
//   end_process         high while HALTED
//   illegal             sticky undefined-opcode / bad-register flag
//   ac_out              accumulator for debug
// OPC_W is expected to be at least 5.
module acc_proc_core
  import acc_proc_core_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 12,
  parameter int NUM_GPR = 4,
  parameter int OPC_W   = 5,
  localparam int INSTR_W = OPC_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic               dm_req,
  output logic               dm_we,
  output logic [DATA_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  input  logic [DATA_W-1:0]  dm_rdata,
  input  logic               dm_ack,
  output logic               end_process,
  output logic               illegal,
  output logic [DATA_W-1:0]  ac_out
);

  state_e              state, state_next;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   ac, ar;
  logic                z, illegal_q;
  logic [DATA_W-1:0]   gpr [NUM_GPR];

  logic [OPC_W-1:0]    opc;
  logic [DATA_W-1:0]   operand;
  opcode_e             op_dec;
  logic                op_ok, reg_ok;
  logic [DATA_W-1:0]   rk;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;

  assign opc     = ir[INSTR_W-1:DATA_W];
  assign operand = ir[DATA_W-1:0];

  // Decode. The register index is range checked against the whole operand,
  // so an index like 5 with four registers is flagged rather than aliased.
  // Anything undefined is turned into a NOP so it cannot change state.
  always_comb begin
    op_dec = OP_NOP;
    op_ok  = 1'b0;
    rk     = '0;
    reg_ok = (operand < DATA_W'(NUM_GPR));
    for (int i = 0; i < NUM_GPR; i++)
      if (operand == DATA_W'(i)) rk = gpr[i];
    if (((opc >> OPC_BASE_W) == '0) && op_defined(opc[OPC_BASE_W-1:0])) begin
      if (!op_uses_reg(opcode_e'(opc[OPC_BASE_W-1:0])) || reg_ok) begin
        op_dec = opcode_e'(opc[OPC_BASE_W-1:0]);
        op_ok  = 1'b1;
      end
    end
  end

  acc_proc_core_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_dec),
    .ac     (ac),
    .rk     (rk),
    .imm    (operand),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. Memory ops stall in MEM until the ack arrives.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_HALTED: if (start) state_next = ST_FETCH;
      ST_FETCH:           state_next = ST_LOAD;
      ST_LOAD:            state_next = ST_EXEC;
      ST_EXEC: begin
        if ((op_dec == OP_LDM) || (op_dec == OP_STM)) state_next = ST_MEM;
        else if (op_dec == OP_HALT)                   state_next = ST_HALTED;
        else                                          state_next = ST_FETCH;
      end
      ST_MEM:             if (dm_ack) state_next = ST_FETCH;
      default:            state_next = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of state and registers, so a reset drops
  // dm_req in the cycle after it is sampled.
  always_comb begin
    im_addr     = pc;
    dm_req      = (state == ST_MEM);
    dm_we       = (state == ST_MEM) && (op_dec == OP_STM);
    dm_addr     = ar;
    dm_wdata    = ac;
    end_process = (state == ST_HALTED);
    illegal     = illegal_q;
    ac_out      = ac;
  end

  // Datapath. A jump in EXEC overrides the increment done in LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      ac        <= '0;
      ar        <= '0;
      z         <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: if (start) pc <= '0;
        ST_LOAD: begin
          ir <= im_data;
          pc <= pc + ADDR_W'(1);
        end
        ST_EXEC: begin
          if (!op_ok) illegal_q <= 1'b1;
          if (op_writes_ac(op_dec)) begin
            ac <= alu_result;
            z  <= alu_zero;
          end
          case (op_dec)
            OP_MOVR:
              for (int i = 0; i < NUM_GPR; i++)
                if (operand == DATA_W'(i)) gpr[i] <= ac;
            OP_LDAR:  ar <= ac;
            OP_INCAR: ar <= ar + DATA_W'(1);
            OP_JMP:   pc <= ADDR_W'(operand);
            OP_JMPZ:  if (z)  pc <= ADDR_W'(operand);
            OP_JMPNZ: if (!z) pc <= ADDR_W'(operand);
            default: ;
          endcase
        end
        ST_MEM: begin
          if (dm_ack && (op_dec == OP_LDM)) begin
            ac <= dm_rdata;
            z  <= (dm_rdata == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_proc_core.sv
// Directed testbench for acc_proc_core with default parameters.
// Models a synchronous instruction memory and a data memory that answers
// dm_req after a programmable number of wait cycles.
module tb_acc_proc_core;
  import acc_proc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] im_addr;
  logic [16:0] im_data = '0;
  logic        dm_req, dm_we;
  logic [11:0] dm_addr, dm_wdata;
  logic [11:0] dm_rdata = '0;
  logic        dm_ack = 1'b0;
  logic        end_process, illegal;
  logic [11:0] ac_out;

  int vec_count = 0;
  int miscompares = 0;

  logic [16:0] imem [4096];
  logic [11:0] dmem [4096];
  int          ack_delay = 0;
  int          req_cnt = 0;
  logic        spurious_ack = 1'b0;
  logic [11:0] wr_addr = '0, wr_data = '0;
  int          wr_count = 0;

  acc_proc_core dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .end_process (end_process),
    .illegal     (illegal),
    .ac_out      (ac_out)
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, data valid one cycle after address.
  always @(posedge clk) im_data <= imem[im_addr];

  // Data memory responder: acks in the (ack_delay+1)-th cycle of a request.
  // Outside a request it can drive a spurious ack that the core must ignore.
  always @(negedge clk) begin
    if (dm_req) begin
      req_cnt  = req_cnt + 1;
      dm_ack   = (req_cnt == ack_delay + 1);
      dm_rdata = dmem[dm_addr];
      if (dm_ack && dm_we) begin
        dmem[dm_addr] = dm_wdata;
        wr_addr  = dm_addr;
        wr_data  = dm_wdata;
        wr_count = wr_count + 1;
      end
    end else begin
      req_cnt = 0;
      dm_ack  = spurious_ack;
    end
  end

  function automatic logic [16:0] ins(input logic [4:0] op, input logic [11:0] v);
    return {op, v};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = ins(OP_HALT, 12'h000);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // halt_n = number of clock edges after the start edge at which
  // end_process is first seen, or -1 on timeout.
  task automatic run_to_halt(input int max_cycles, output int halt_n);
    halt_n = -1;
    for (int n = 1; n <= max_cycles; n++) begin
      @(negedge clk);
      if (end_process) begin
        halt_n = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    vec_count++; if (ac_out !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_ac: got %h expected 000", ac_out); end
    vec_count++; if (end_process !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_end: got %b expected 0", end_process); end
    vec_count++; if (illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_illegal: got %b expected 0", illegal); end
    vec_count++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dm: got req=%b we=%b expected 0 0", dm_req, dm_we); end
    vec_count++; if (im_addr !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_pc: got %h expected 000", im_addr); end
    vec_count++; if (dm_addr !== 12'h000 || dm_wdata !== 12'h000) begin miscompares++; $display("[TB] FAIL rst_dmbus: got addr=%h wdata=%h expected 000 000", dm_addr, dm_wdata); end
  endtask

  task automatic test_basic();
    int halt_n;
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h005);
    imem[1] = ins(OP_ADD, 12'h000);
    imem[2] = ins(OP_HALT, 12'h000);
    pulse_start();
    run_to_halt(50, halt_n);
    vec_count++; if (halt_n !== 9) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 9", halt_n); end
    vec_count++; if (ac_out !== 12'h005) begin miscompares++; $display("[TB] FAIL basic_ac: got %h expected 005", ac_out); end
    vec_count++; if (im_addr !== 12'h003) begin miscompares++; $display("[TB] FAIL basic_pc: got %h expected 003", im_addr); end
  endtask

  task automatic test_wrap();
    int halt_n;
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h007);
    imem[1] = ins(OP_MOVR, 12'h001);
    imem[2] = ins(OP_LDI, 12'hFFF);
    imem[3] = ins(OP_ADD, 12'h001);
    imem[4] = ins(OP_JMPNZ, 12'h040);
    pulse_start();
    run_to_halt(80, halt_n);
    vec_count++; if (halt_n !== 18) begin miscompares++; $display("[TB] FAIL wrap_latency: got %0d expected 18", halt_n); end
    vec_count++; if (ac_out !== 12'h006) begin miscompares++; $display("[TB] FAIL wrap_ac: got %h expected 006", ac_out); end
    vec_count++; if (im_addr !== 12'h041) begin miscompares++; $display("[TB] FAIL wrap_znz: got pc %h expected 041", im_addr); end
    clear_imem();
    imem[0] = ins(OP_SUB, 12'h001);
    imem[1] = ins(OP_SUB, 12'h001);
    pulse_start();
    run_to_halt(50, halt_n);
    vec_count++; if (halt_n !== 9) begin miscompares++; $display("[TB] FAIL sub_latency: got %0d expected 9", halt_n); end
    vec_count++; if (ac_out !== 12'hFF8) begin miscompares++; $display("[TB] FAIL sub_ac: got %h expected ff8", ac_out); end
  endtask

  task automatic test_mem();
    int halt_n, req_cycles, bad;
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h003);
    imem[1] = ins(OP_LDAR, 12'h000);
    imem[2] = ins(OP_LDI, 12'h0AB);
    imem[3] = ins(OP_STM, 12'h000);
    ack_delay = 4;
    wr_count = 0;
    req_cycles = 0;
    bad = 0;
    halt_n = -1;
    pulse_start();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (dm_req) begin
        req_cycles++;
        if (dm_addr !== 12'h003 || dm_wdata !== 12'h0AB || dm_we !== 1'b1) bad++;
      end
      if (n == 17) begin
        vec_count++; if (im_addr !== 12'h004 || dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL stm_refetch: got pc=%h req=%b expected 004 0", im_addr, dm_req); end
      end
      if (end_process) begin
        halt_n = n;
        break;
      end
    end
    vec_count++; if (req_cycles !== 5) begin miscompares++; $display("[TB] FAIL stm_req_len: got %0d expected 5", req_cycles); end
    vec_count++; if (bad !== 0) begin miscompares++; $display("[TB] FAIL stm_stable: got %0d unstable cycles expected 0", bad); end
    vec_count++; if (halt_n !== 20) begin miscompares++; $display("[TB] FAIL stm_latency: got %0d expected 20", halt_n); end
    vec_count++; if (wr_count !== 1 || wr_addr !== 12'h003 || wr_data !== 12'h0AB) begin miscompares++; $display("[TB] FAIL stm_write: got n=%0d addr=%h data=%h expected 1 003 0ab", wr_count, wr_addr, wr_data); end
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h000);
    imem[1] = ins(OP_LDM, 12'h000);
    ack_delay = 0;
    pulse_start();
    run_to_halt(50, halt_n);
    vec_count++; if (halt_n !== 10) begin miscompares++; $display("[TB] FAIL ldm_latency: got %0d expected 10", halt_n); end
    vec_count++; if (ac_out !== 12'h0AB) begin miscompares++; $display("[TB] FAIL ldm_ac: got %h expected 0ab", ac_out); end
  endtask

  task automatic test_jump();
    int halt_n;
    clear_imem();
    imem[12'h000] = ins(OP_CLR, 12'h000);
    imem[12'h001] = ins(OP_JMPZ, 12'h010);
    imem[12'h010] = ins(OP_INC, 12'h000);
    imem[12'h011] = ins(OP_JMPZ, 12'h020);
    imem[12'h012] = ins(OP_HALT, 12'h000);
    spurious_ack = 1'b1;
    halt_n = -1;
    pulse_start();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      if (n == 6) begin
        vec_count++; if (im_addr !== 12'h010) begin miscompares++; $display("[TB] FAIL jmpz_taken: got pc %h expected 010", im_addr); end
      end
      if (end_process) begin
        halt_n = n;
        break;
      end
    end
    start = 1'b0;
    spurious_ack = 1'b0;
    vec_count++; if (halt_n !== 15) begin miscompares++; $display("[TB] FAIL jump_latency: got %0d expected 15", halt_n); end
    vec_count++; if (im_addr !== 12'h013) begin miscompares++; $display("[TB] FAIL jmpz_not_taken: got pc %h expected 013", im_addr); end
    vec_count++; if (ac_out !== 12'h001) begin miscompares++; $display("[TB] FAIL jump_ac: got %h expected 001", ac_out); end
  endtask

  task automatic test_illegal();
    int halt_n;
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h055);
    imem[1] = ins(5'd20, 12'h000);
    imem[2] = ins(OP_MOVR, 12'h005);
    imem[3] = ins(OP_MOVA, 12'h001);
    halt_n = -1;
    pulse_start();
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 5) begin
        vec_count++; if (illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_early: got %b expected 0", illegal); end
      end
      if (n == 6) begin
        vec_count++; if (illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_set: got %b expected 1", illegal); end
      end
      if (end_process) begin
        halt_n = n;
        break;
      end
    end
    vec_count++; if (halt_n !== 15) begin miscompares++; $display("[TB] FAIL illegal_latency: got %0d expected 15", halt_n); end
    vec_count++; if (ac_out !== 12'h007) begin miscompares++; $display("[TB] FAIL illegal_gpr: got ac %h expected 007", ac_out); end
    vec_count++; if (illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_sticky: got %b expected 1", illegal); end
  endtask

  task automatic test_reset_mid();
    int halt_n;
    logic seen;
    clear_imem();
    imem[0] = ins(OP_LDM, 12'h000);
    ack_delay = 20;
    seen = 1'b0;
    pulse_start();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (dm_req) begin
        seen = 1'b1;
        break;
      end
    end
    vec_count++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_req: got %b expected 1", seen); end
    rst = 1'b1;
    @(negedge clk);
    vec_count++; if (dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_drop: got %b expected 0", dm_req); end
    vec_count++; if (illegal !== 1'b0 || ac_out !== 12'h000 || end_process !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_regs: got ill=%b ac=%h end=%b expected 0 000 0", illegal, ac_out, end_process); end
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vec_count++; if (im_addr !== 12'h000 || dm_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_over_start: got pc=%h req=%b expected 000 0", im_addr, dm_req); end
    clear_imem();
    imem[0] = ins(OP_LDI, 12'h02C);
    ack_delay = 0;
    pulse_start();
    vec_count++; if (im_addr !== 12'h000) begin miscompares++; $display("[TB] FAIL restart_pc: got %h expected 000", im_addr); end
    run_to_halt(40, halt_n);
    vec_count++; if (halt_n !== 6) begin miscompares++; $display("[TB] FAIL restart_latency: got %0d expected 6", halt_n); end
    vec_count++; if (ac_out !== 12'h02C) begin miscompares++; $display("[TB] FAIL restart_ac: got %h expected 02c", ac_out); end
  endtask

  // Scenarios run in order; later ones rely on register state left behind
  // by earlier ones (R1=7 from test_wrap, AR=3 from test_mem).
  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = '0;
    clear_imem();
    test_reset();
    test_basic();
    test_wrap();
    test_mem();
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
